// File: rtl/rv32i_instr_encoder.sv
// RV32I field-to-word encoder with legality checks,
// a 2-entry output FIFO and saturating counters.
module rv32i_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        is_i, is_s, is_b, is_u, is_j, is_r;
  logic        is_shift;
  logic        i_ok, sh_ok, b_ok, j_ok, u_ok;
  logic [31:0] enc;
  logic [2:0]  code;
  logic        accept, push, pop;

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  assign is_i = (in_fmt == FMT_I);
  assign is_s = (in_fmt == FMT_S);
  assign is_b = (in_fmt == FMT_B);
  assign is_u = (in_fmt == FMT_U);
  assign is_j = (in_fmt == FMT_J);
  assign is_r = (in_fmt == FMT_R);

  assign is_shift = is_i
    && (in_opcode == 7'b0010011)
    && ((in_funct3 == 3'b001)
     || (in_funct3 == 3'b101));

  // Sign-extension checks: upper bits all equal to the top kept bit
  assign i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sh_ok = ~(|in_imm[31:5]);
  assign b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12]))
               & ~in_imm[0];
  assign j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20]))
               & ~in_imm[0];
  assign u_ok  = ~(|in_imm[11:0]);

  always_comb begin
    enc = '0;
    unique case (1'b1)
      is_r: enc = {in_funct7, in_rs2, in_rs1,
                   in_funct3, in_rd, in_opcode};
      is_shift: enc = {in_funct7, in_imm[4:0], in_rs1,
                       in_funct3, in_rd, in_opcode};
      is_i && !is_shift:
        enc = {in_imm[11:0], in_rs1,
               in_funct3, in_rd, in_opcode};
      is_s: enc = {in_imm[11:5], in_rs2, in_rs1,
                   in_funct3, in_imm[4:0], in_opcode};
      is_b: enc = {in_imm[12], in_imm[10:5], in_rs2,
                   in_rs1, in_funct3, in_imm[4:1],
                   in_imm[11], in_opcode};
      is_u: enc = {in_imm[31:12], in_rd, in_opcode};
      is_j: enc = {in_imm[20], in_imm[10:1], in_imm[11],
                   in_imm[19:12], in_rd, in_opcode};
      default: enc = '0;
    endcase
  end

  always_comb begin
    code = 3'd0;
    if (in_opcode[1:0] != 2'b11)
      code = 3'd1;
    else if (!(is_i || is_s || is_b || is_u || is_j || is_r))
      code = 3'd2;
    else if ((is_i && !(is_shift ? sh_ok : i_ok))
          || (is_s && !i_ok))
      code = 3'd3;
    else if (is_b && !b_ok)
      code = 3'd4;
    else if (is_j && !j_ok)
      code = 3'd5;
    else if (is_u && !u_ok)
      code = 3'd6;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? mem[rd_ptr] : '0;

  assign accept = in_valid && in_ready;
  assign push   = accept && (code == 3'd0);
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      err_valid   <= 1'b0;
      err_code    <= 3'd0;
      instr_count <= '0;
      err_count   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= ~wr_ptr;
        if (instr_count != CNT_MAX)
          instr_count <= instr_count + CNT_ONE;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      err_valid <= accept && (code != 3'd0);
      if (accept && (code != 3'd0)) begin
        err_code <= code;
        if (err_count != CNT_MAX)
          err_count <= err_count + CNT_ONE;
      end
    end
  end

endmodule
